arb_client: RTL and testbench
=============================

Name: arb_client

Overview:
- Requester-side agent for the 4-way round-robin arbiter (`req[i]`/`grant[i]` pair); one instance per arbiter port.
- Queues local burst commands in a small FIFO and raises `req` for each one.
- Waits for `grant`, then drives one beat per granted cycle for the burst length, drops `req`, and observes a programmable idle gap before re-requesting.
- Flags requests that stall too long without a grant.

Parameters:
- DEPTH, 4: command FIFO entries (power of 2, ≥2).
- LEN_W, 4: width of `cmd_len`; burst = `cmd_len`+1 beats (1..16).
- TIMEOUT, 16: cycles in REQ without grant before `timeout_err` pulses (≥1).
- GAP, 1: idle cycles with `req`=0 after each burst (0 allowed).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_len  input  LEN_W  burst length minus one.
- req  output  1  request to arbiter, registered.
- grant  input  1  grant from arbiter for this port.
- beat_valid  output  1  one resource beat this cycle.
- beat_last  output  1  final beat of the burst; only with beat_valid.
- busy  output  1  state != IDLE or FIFO non-empty.
- timeout_err  output  1  one-cycle pulse, registered.
- grant_cnt  output  16  grants won (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; FIFO emptied (pointers and count 0).
  - `req`=0, `timeout_err`=0, beat counter=0, wait counter=0, gap counter=0, `grant_cnt`=0.
  - `beat_valid`/`beat_last`=0 because state is IDLE.
  - Applies mid-burst too: in-flight burst and queued commands are discarded; `req` is low the cycle after the reset edge.
- FIFO:
  - Push when `cmd_valid`&&`cmd_ready`.
  - Pop only on the REQ->OWN transition; head `cmd_len` is loaded into the beat counter.
  - Full: `cmd_ready`=0, `cmd_valid` ignored.
  - Push and pop in the same cycle: count unchanged.
  - A push into an empty FIFO is visible to the FSM the next cycle.
- FSM states: IDLE, REQ, OWN, GAP. `req` is registered and high exactly in REQ and OWN.
- IDLE:
  - FIFO non-empty -> REQ; `req`=1 from the next cycle.
  - Otherwise stay.
- REQ:
  - `grant`=1 sampled -> OWN; pop FIFO; beat counter = `cmd_len`; wait counter cleared; `grant_cnt`+1 (if enabled).
  - Otherwise increment the wait counter. When it reaches TIMEOUT, pulse `timeout_err` for one cycle, clear the counter and stay in REQ with `req` held. Repeats every TIMEOUT cycles while ungranted.
- OWN:
  - `beat_valid` = `grant` (combinational from state and grant).
  - Beat counter decrements on each granted cycle.
  - `beat_last` = `beat_valid` && counter==0.
  - `grant`=0 in OWN: stall; no beat, counter holds, `req` stays high, no timeout counting.
  - On the `beat_last` cycle: -> GAP if GAP>0, else -> IDLE. `req`=0 the following cycle.
  - GAP=0 with a non-empty FIFO: IDLE then REQ, so `req` is low for exactly one cycle between bursts. This minimum lets the arbiter rotate.
- GAP:
  - Count GAP cycles, then -> IDLE. `req`=0 throughout.
  - New commands may still be pushed.
- Latency:
  - Push into an empty idle block: `req` high 2 cycles after the push edge.
  - `grant` seen -> first `beat_valid` the next cycle, if `grant` is still high.
- Arithmetic:
  - Beat counter is LEN_W bits; `cmd_len`=all-ones gives 2^LEN_W beats with no wrap.
  - Wait counter is clog2(TIMEOUT+1) bits.
  - `grant_cnt` saturates at 16'hFFFF.
- `grant` outside REQ/OWN is ignored. The bench flags it as an arbiter protocol error; the RTL takes no action.

Optional Feature:
- Macro: ARB_CLIENT_STATS_EN.
- Defined: `grant_cnt` counts REQ->OWN transitions, saturating at 16'hFFFF, cleared by rst.
- Undefined: counter logic is not compiled; `grant_cnt` is tied to 16'h0000. The port exists in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, `cmd_valid`=0 -> `req`=0, `cmd_ready`=1, `busy`=0, `timeout_err`=0, `grant_cnt`=0.
- Single burst: push `cmd_len`=2; `grant` tied high from the first `req` cycle -> `req` for 4 cycles (REQ + 3 OWN), `beat_valid` 3 cycles, `beat_last` on the 3rd, `req` low for GAP=1 cycle, `grant_cnt`=1 (STATS_EN).
- Stall in OWN: `cmd_len`=3; drop `grant` for 2 cycles mid-burst -> 4 beats total, `req` high continuously, no `timeout_err`.
- Timeout: push a command, hold `grant`=0 for 40 cycles with TIMEOUT=16 -> `timeout_err` pulses at 16 and 32 cycles after `req` rises; `req` stays 1; grant at cycle 40 -> burst completes normally.
- FIFO full/back-to-back: push 5 commands `cmd_len`=0 with DEPTH=4, `grant` always 1 -> `cmd_ready`=0 after the 4th push; the 5th is held by the source until a pop. 5 single-beat bursts, each separated by GAP+1 cycles of `req`=0 (GAP=0: exactly 1 cycle). `grant_cnt`=5.
- Reset mid-burst: assert rst during the 2nd beat of a 4-beat burst with 2 queued commands -> next cycle `req`=0, `beat_valid`=0, `busy`=0, `cmd_ready`=1; no further bursts.

Source files
------------

// File: rtl/arb_client.sv
// Requester-side agent for one port of a round-robin arbiter: queues burst commands,
// requests, streams granted beats and flags long waits. Define ARB_CLIENT_STATS_EN for grant_cnt.
module arb_client #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req,
  input  logic             grant,
  output logic             beat_valid,
  output logic             beat_last,
  output logic             busy,
  output logic             timeout_err,
  output logic [15:0]      grant_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_GAP} state_t;

  state_t           state;
  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [LEN_W-1:0] beat_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             full, push, pop;

  assign full       = (count == CW'(DEPTH));
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign pop        = (state == S_REQ) && grant;
  assign beat_valid = (state == S_OWN) && grant;
  assign beat_last  = beat_valid && (beat_cnt == '0);
  assign busy       = (state != S_IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Stalls in OWN (grant low) neither consume a beat nor count towards the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req         <= 1'b0;
      timeout_err <= 1'b0;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state    <= S_REQ;
            req      <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_REQ: begin
          if (grant) begin
            state    <= S_OWN;
            beat_cnt <= mem[rd_ptr];
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_OWN: begin
          if (grant) begin
            if (beat_cnt == '0) begin
              req     <= 1'b0;
              gap_cnt <= '0;
              state   <= (GAP > 0) ? S_GAP : S_IDLE;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_CLIENT_STATS_EN
  logic [15:0] grant_q;

  always_ff @(posedge clk) begin
    if (rst) grant_q <= '0;
    else if (pop && (grant_q != 16'hFFFF)) grant_q <= grant_q + 1'b1;
  end

  assign grant_cnt = grant_q;
`else
  assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_arb_client.sv
// Self-checking bench for arb_client: a queue-based model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_arb_client;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 1;
`ifdef ARB_CLIENT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             grant = 1'b0;
  logic             cmd_ready, req, beat_valid, beat_last, busy, timeout_err;
  logic [15:0]      grant_cnt;

  arb_client #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .req(req), .grant(grant), .beat_valid(beat_valid),
    .beat_last(beat_last), .busy(busy), .timeout_err(timeout_err), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checking = 0;
  bit auto_grant = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a command queue, the burst in hand as "beats remaining", and gap cycles left.
  int m_q[$];
  bit m_active, m_owned, m_terr;
  int m_left, m_wait, m_gap, m_gcnt;

  always @(posedge clk) begin
    bit push_ok;
    push_ok = cmd_valid && (m_q.size() < DEPTH);
    m_terr = 0;
    if (rst) begin
      m_q.delete();
      m_active = 0; m_owned = 0; m_left = 0; m_wait = 0; m_gap = 0; m_gcnt = 0;
    end else begin
      if (m_gap > 0) m_gap--;
      else if (!m_active) begin
        if (m_q.size() > 0) begin m_active = 1; m_wait = 0; end
      end else if (!m_owned) begin
        if (grant) begin
          m_owned = 1;
          m_left = m_q.pop_front() + 1;
          m_wait = 0;
          if (m_gcnt < 65535) m_gcnt++;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin m_terr = 1; m_wait = 0; end
        end
      end else if (grant) begin
        m_left--;
        if (m_left == 0) begin m_active = 0; m_owned = 0; m_gap = GAP; end
      end
      if (push_ok) m_q.push_back(int'(cmd_len));
    end
  end

  // Observed activity for the directed scenarios.
  int req_cycles, beats, lasts, terrs, rises, low_run;
  bit prev_req, had_high;
  int low_runs[$];

  task automatic clearStats();
    req_cycles = 0; beats = 0; lasts = 0; terrs = 0; rises = 0; low_run = 0;
    had_high = 0; low_runs.delete();
  endtask

  always @(negedge clk) begin
    if (checking) begin
      bit exp_bv;
      exp_bv = m_owned && grant;
      checkOutput("req", req, m_active);
      checkOutput("cmd_ready", cmd_ready, m_q.size() < DEPTH);
      checkOutput("busy", busy, m_active || m_gap > 0 || m_q.size() > 0);
      checkOutput("beat_valid", beat_valid, exp_bv);
      checkOutput("beat_last", beat_last, exp_bv && m_left == 1);
      checkOutput("timeout_err", timeout_err, m_terr);
      checkOutput("grant_cnt", grant_cnt, STATS ? m_gcnt : 0);
      checkOutput("grant_protocol", grant && !m_active, 0);
      if (req) req_cycles++;
      if (beat_valid) beats++;
      if (beat_last) lasts++;
      if (timeout_err) terrs++;
      if (req && !prev_req) begin
        rises++;
        if (had_high) low_runs.push_back(low_run);
      end
      if (req) begin low_run = 0; had_high = 1; end
      else low_run++;
      prev_req = req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_grant) grant = req;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic applyStimulus(input int len);
    bit ok;
    ok = 0;
    cmd_valid = 1'b1;
    cmd_len = LEN_W'(len);
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    checkOutput("push_accepted", ok, 1);
  endtask

  task automatic resetDut();
    auto_grant = 0;
    grant = 0;
    rst = 1;
    run(2);
    rst = 0;
  endtask

  initial begin
    int p0, p1;
    clearStats();
    prev_req = 0;

    $display("[TB] reset then idle");
    step();
    checking = 1;
    step();
    rst = 0;
    checkOutput("rst_req", req, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_grant_cnt", grant_cnt, 0);
    run(3);
    checkOutput("idle_req", req, 0);

    $display("[TB] single burst");
    resetDut();
    clearStats();
    auto_grant = 1;
    applyStimulus(2);
    checkOutput("lat_req_low", req, 0);
    checkOutput("lat_busy", busy, 1);
    step();
    checkOutput("lat_req_high", req, 1);
    run(12);
    checkOutput("single_req_cycles", req_cycles, 4);
    checkOutput("single_beats", beats, 3);
    checkOutput("single_lasts", lasts, 1);
    checkOutput("single_grant_cnt", grant_cnt, STATS ? 1 : 0);

    $display("[TB] stall in own");
    resetDut();
    clearStats();
    auto_grant = 1;
    applyStimulus(3);
    run(3);
    auto_grant = 0;
    grant = 0;
    run(2);
    auto_grant = 1;
    grant = req;
    run(14);
    checkOutput("stall_beats", beats, 4);
    checkOutput("stall_lasts", lasts, 1);
    checkOutput("stall_req_cycles", req_cycles, 7);
    checkOutput("stall_rises", rises, 1);
    checkOutput("stall_timeouts", terrs, 0);

    $display("[TB] timeout");
    resetDut();
    clearStats();
    applyStimulus(1);
    step();
    checkOutput("to_req_rise", req, 1);
    begin
      int pulses[$];
      for (int k = 1; k <= 40; k++) begin
        step();
        if (timeout_err) pulses.push_back(k);
      end
      checkOutput("to_pulse_count", pulses.size(), 2);
      p0 = (pulses.size() > 0) ? pulses[0] : -1;
      p1 = (pulses.size() > 1) ? pulses[1] : -1;
      checkOutput("to_first_pulse", p0, 16);
      checkOutput("to_second_pulse", p1, 32);
    end
    checkOutput("to_req_held", req, 1);
    auto_grant = 1;
    grant = req;
    run(10);
    checkOutput("to_beats", beats, 2);
    checkOutput("to_lasts", lasts, 1);

    $display("[TB] fifo full and back-to-back");
    resetDut();
    clearStats();
    for (int i = 0; i < 4; i++) applyStimulus(0);
    checkOutput("full_cmd_ready", cmd_ready, 0);
    auto_grant = 1;
    grant = req;
    applyStimulus(0);
    run(30);
    checkOutput("b2b_beats", beats, 5);
    checkOutput("b2b_lasts", lasts, 5);
    checkOutput("b2b_gap_count", low_runs.size(), 4);
    foreach (low_runs[i]) checkOutput("b2b_gap_len", low_runs[i], 2);
    checkOutput("b2b_grant_cnt", grant_cnt, STATS ? 5 : 0);

    $display("[TB] reset mid-burst");
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(3);
    auto_grant = 1;
    grant = req;
    run(2);
    checkOutput("mid_beat_valid", beat_valid, 1);
    rst = 1;
    step();
    checkOutput("mid_req", req, 0);
    checkOutput("mid_beat_off", beat_valid, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_cmd_ready", cmd_ready, 1);
    checkOutput("mid_grant_cnt", grant_cnt, 0);
    rst = 0;
    clearStats();
    run(20);
    checkOutput("mid_no_beats", beats, 0);
    checkOutput("mid_no_req", req_cycles, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
